// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake into the UART transmit FIFO.
// The producer holds s_valid/s_data; a word is taken on any edge where s_ready is also high.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter. A pushed word starts its frame one cycle after it becomes poppable; txd is registered.
// Backpressure: s_ready drops while the FIFO is full or reset is high. Break requests win over queued data in IDLE.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [BAUD_W-1:0]             baudrate,
  input  logic [2:0]                    parity_sel,
  input  logic                          stop_sel,
  input  logic                          break_req,
  uart_tx_fifo_if.slave                 s_if,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          done
);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              push, pop, fsm_pop;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              txd_q, txd_d;
  logic              bit_end;

  assign s_if.s_ready = !reset && (level_q != FULL_LVL);
  assign push         = s_if.s_valid && s_if.s_ready;
  assign pop          = fsm_pop && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (push) mem_q[wr_ptr_q] <= s_if.s_data;
  end

  assign bit_end = (baud_cnt_q == baud_q);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    fsm_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (break_req) begin
          state_d = S_BREAK;
          txd_d   = 1'b0;
          baud_d  = baudrate;
        end else if (level_q != '0) begin
          // Line settings are captured with the word so mid-frame changes wait for the next frame.
          fsm_pop   = 1'b1;
          state_d   = S_START;
          txd_d     = 1'b0;
          baud_d    = baudrate;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          stop2_d   = stop_sel;
          par_en_d  = (parity_sel >= 3'd1) && (parity_sel <= 3'd4);
          case (parity_sel)
            3'd1:    par_bit_d = ^mem_q[rd_ptr_q];
            3'd2:    par_bit_d = ~^mem_q[rd_ptr_q];
            3'd3:    par_bit_d = 1'b1;
            default: par_bit_d = 1'b0;
          endcase
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
            txd_d     = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == 4'd0)) begin
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            txd_d     = 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Counter saturates once the minimum one-bit break has elapsed.
        if (bit_end) begin
          baud_cnt_d = baud_q;
          if (!break_req) begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_level = level_q;
  assign done       = (state_q == S_IDLE) && (level_q == '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: waveform-level reference model compared every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 16;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] baudrate = 16'd3;
  logic [2:0]    parity_sel = 3'd0;
  logic          stop_sel = 1'b0;
  logic          break_req = 1'b0;
  logic          txd, busy, done;
  logic [2:0]    fifo_level;

  uart_tx_fifo_if #(.DATA_W(DW)) s_if();

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
    .mclk(mclk), .reset(reset), .baudrate(baudrate), .parity_sel(parity_sel),
    .stop_sel(stop_sel), .break_req(break_req), .s_if(s_if), .txd(txd),
    .busy(busy), .fifo_level(fifo_level), .done(done)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, each frame expanded into its txd waveform.
  logic [DW-1:0] mq[$];
  bit            wave[$];
  int            m_mode = 0;   // 0 idle, 1 frame, 2 break
  logic          m_txd = 1'b1;
  int            brk_cycles, brk_len;

  task automatic build_frame(input logic [DW-1:0] w);
    bit b[$];
    int rep;
    rep = int'(baudrate) + 1;
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(w[i]);
    case (parity_sel)
      3'd1: b.push_back(^w);
      3'd2: b.push_back(~^w);
      3'd3: b.push_back(1'b1);
      3'd4: b.push_back(1'b0);
      default: ;
    endcase
    b.push_back(1'b1);
    if (stop_sel) b.push_back(1'b1);
    wave.delete();
    foreach (b[k]) for (int r = 0; r < rep; r++) wave.push_back(b[k]);
  endtask

  always @(posedge mclk) begin
    int sz;
    bit do_push;
    sz = mq.size();
    do_push = s_if.s_valid && !reset && (sz != DEPTH);
    if (reset) begin
      mq.delete();
      wave.delete();
      m_mode = 0;
      m_txd  = 1'b1;
    end else begin
      case (m_mode)
        1: begin
          if (wave.size() > 0) m_txd = wave.pop_front();
          else begin m_mode = 0; m_txd = 1'b1; end
        end
        2: begin
          brk_cycles++;
          if (brk_cycles >= brk_len && !break_req) begin m_mode = 0; m_txd = 1'b1; end
        end
        default: begin
          if (break_req) begin
            m_mode = 2; brk_cycles = 0; brk_len = int'(baudrate) + 1; m_txd = 1'b0;
          end else if (sz > 0) begin
            build_frame(mq.pop_front());
            m_mode = 1;
            m_txd  = wave.pop_front();
          end
        end
      endcase
      if (do_push) mq.push_back(s_if.s_data);
    end
  end

  always @(negedge mclk) begin
    if (chk_en) begin
      check("txd", {31'd0, txd}, {31'd0, m_txd});
      check("busy", {31'd0, busy}, 32'(m_mode != 0));
      check("fifo_level", {29'd0, fifo_level}, 32'(mq.size()));
      check("s_ready", {31'd0, s_if.s_ready}, 32'(!reset && mq.size() != DEPTH));
      check("done", {31'd0, done}, 32'(m_mode == 0 && mq.size() == 0));
    end
  end

  logic cap_txd [200];
  logic cap_busy[200];
  logic cap_done[200];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      cap_txd[i] = txd; cap_busy[i] = busy; cap_done[i] = done;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    s_if.s_valid = 1'b1; s_if.s_data = w;
    tick();
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin tick(); n++; end
    check(nm, 32'(n < limit), 32'd1);
  endtask

  task automatic send_capture(input logic [DW-1:0] w, input logic [2:0] par, input logic st,
                              output int s, output int len);
    parity_sel = par; stop_sel = st;
    push_word(w);
    capture(60);
    s = -1;
    for (int i = 0; i < 60; i++) if (s < 0 && cap_txd[i] === 1'b0) s = i;
    check("frame_start_seen", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    len = 0;
    for (int i = s; i < 60 && cap_busy[i] === 1'b1; i++) len++;
  endtask

  initial begin
    bit   exp_a5[10];
    bit   exp_par[4];
    int   s, len, e, zeros, brk_hold;
    exp_a5  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_par = '{1'b1, 1'b0, 1'b1, 1'b0};
    s_if.s_valid = 1'b0; s_if.s_data = '0;

    tick();
    chk_en = 1'b1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    reset = 1'b0;
    #1;
    check("post_rst_s_ready", {31'd0, s_if.s_ready}, 32'd1);
    check("post_rst_done", {31'd0, done}, 32'd1);

    // 0xA5, no parity, one stop, 4 cycles per bit
    baudrate = 16'd3;
    send_capture(8'hA5, 3'd0, 1'b0, s, len);
    check("a5_latency", 32'(s), 32'd1);
    for (int i = 0; i < 10; i++) check("a5_bit", {31'd0, cap_txd[s + 4*i + 1]}, {31'd0, exp_a5[i]});
    check("a5_len", 32'(len), 32'd40);
    check("a5_done_after", {31'd0, cap_done[s + 40]}, 32'd1);

    for (int p = 1; p <= 4; p++) begin
      send_capture(8'h07, 3'(p), 1'(p == 4), s, len);
      check("parity_bit", {31'd0, cap_txd[s + 4*9 + 1]}, {31'd0, exp_par[p-1]});
      check("parity_len", 32'(len), (p == 4) ? 32'd48 : 32'd44);
    end
    parity_sel = 3'd0; stop_sel = 1'b0;

    // Fill the FIFO while a frame is in flight
    push_word(8'h01);
    tick(3);
    s_if.s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin s_if.s_data = 8'(k * 17); tick(); end
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_s_ready", {31'd0, s_if.s_ready}, 32'd0);
    s_if.s_data = 8'h55; tick();
    s_if.s_valid = 1'b0;
    wait_done("drain_fill", 2000);

    // Baud change mid-frame only affects the next frame
    s_if.s_valid = 1'b1; s_if.s_data = 8'h3C; tick();
    s_if.s_data = 8'hC3; tick();
    s_if.s_valid = 1'b0;
    tick(12);
    baudrate = 16'd7;
    capture(150);
    e = -1;
    for (int i = 0; i < 150; i++) if (e < 0 && cap_busy[i] === 1'b0) e = i;
    check("baud_frame1_end", 32'(e), 32'd28);
    if (e < 0) e = 0;
    len = 0;
    for (int i = e + 1; i < 150 && cap_busy[i] === 1'b1; i++) len++;
    check("baud_frame2_len", 32'(len), 32'd80);
    wait_done("drain_baud", 500);
    baudrate = 16'd3;

    // Break requested mid-frame holds off the queued word
    push_word(8'h5A); push_word(8'h96);
    tick(5);
    break_req = 1'b1;
    tick(100);
    check("break_txd", {31'd0, txd}, 32'd0);
    check("break_level", {29'd0, fifo_level}, 32'd1);
    break_req = 1'b0;
    wait_done("drain_break", 500);

    // One-cycle break request still yields a full bit period of break
    break_req = 1'b1; tick(); break_req = 1'b0;
    capture(10);
    zeros = 0;
    for (int i = 0; i < 10; i++) if (cap_txd[i] === 1'b0) zeros++;
    check("break_min_len", 32'(zeros), 32'd4);
    wait_done("drain_brk_min", 50);

    // Reset during data bit 3 aborts the frame and flushes the queue
    push_word(8'hF0); push_word(8'h0F);
    tick(4*4);
    reset = 1'b1; tick();
    check("rst_mid_txd", {31'd0, txd}, 32'd1);
    check("rst_mid_level", {29'd0, fifo_level}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    capture(60);
    zeros = 0;
    for (int i = 0; i < 60; i++) if (cap_txd[i] === 1'b0) zeros++;
    check("rst_no_restart", 32'(zeros), 32'd0);

    brk_hold = 0;
    for (int it = 0; it < 5000; it++) begin
      s_if.s_valid = ($urandom_range(0, 3) == 0);
      s_if.s_data  = 8'($urandom);
      if ($urandom_range(0, 149) == 0) baudrate = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) parity_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) stop_sel = 1'($urandom_range(0, 1));
      if (brk_hold > 0) begin
        brk_hold--;
        if (brk_hold == 0) break_req = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        break_req = 1'b1;
        brk_hold  = $urandom_range(1, 60);
      end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    s_if.s_valid = 1'b0; break_req = 1'b0; reset = 1'b0;
    wait_done("drain_random", 3000);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 Parameter BAUD_W, default 16, width of the baudrate port.
REQ-004 mclk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the mclk rising edge.
REQ-006 baudrate  input  BAUD_W  bit period minus one, in mclk cycles.
REQ-007 parity_sel  input  3  parity mode: 0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5..7 treated as none.
REQ-008 stop_sel  input  1  stop bits: 0 gives one, 1 gives two.
REQ-009 break_req  input  1  request to hold the line low (break) between frames.
REQ-010 s_valid  input  1  write request for s_data.
REQ-011 s_data  input  DATA_W  word to transmit, LSB first.
REQ-012 s_ready  output  1  FIFO can accept a word.
REQ-013 txd  output  1  registered serial line; idle high.
REQ-014 busy  output  1  high when the FSM is not IDLE.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-016 done  output  1  high when the FSM is IDLE and fifo_level is 0.

Function
REQ-017 FIFO: push on an edge where s_valid & s_ready; s_ready = (fifo_level != FIFO_DEPTH) and reset is low.
REQ-018 Words leave the FIFO in push order; a pushed word is poppable from the cycle after the push.
REQ-019 A simultaneous push and pop leaves fifo_level unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 In IDLE with break_req low and fifo_level > 0, the FSM pops one word and enters START at the next edge.
REQ-022 At that same edge, baudrate, parity_sel and stop_sel are latched; changes to them mid-frame have no effect.
REQ-023 Each of START, each DATA bit, PARITY and each stop bit lasts exactly baudrate+1 mclk cycles; baudrate = 0 gives 1 cycle per bit.
REQ-024 txd is 0 in START; in DATA it carries the data bits LSB first over DATA_W bit periods; it is 1 in STOP and in IDLE.
REQ-025 PARITY is entered after DATA only when the latched parity mode is 1..4; otherwise DATA goes directly to STOP.
REQ-026 Parity bit value: even = XOR of the data bits; odd = its inverse; mark = 1; space = 0.
REQ-027 STOP lasts one bit period, or two bit periods when the latched stop_sel is 1, then the FSM enters IDLE.
REQ-028 The frame length in mclk cycles is (baudrate+1) x (1 + DATA_W + parity bit count + stop bit count).
REQ-029 IDLE lasts at least one cycle between frames; back-to-back frames therefore have a one-cycle idle gap.
REQ-030 txd changes on the same edge as the state transition that defines it, with no added pipeline delay.
REQ-031 In IDLE with break_req high, the FSM enters BREAK (txd = 0) and FIFO pops are suppressed.
REQ-032 break_req asserted during a frame has no effect until that frame's STOP completes.
REQ-033 BREAK exits to IDLE on the edge after break_req is sampled low, and lasts a minimum of one bit period (baudrate+1 cycles).
REQ-034 When a break and pending data compete, break has priority in IDLE.

Reset
REQ-035 While reset is high at an edge: the FSM goes to IDLE, txd = 1, busy = 0, the FIFO is flushed (fifo_level = 0), s_ready = 0, and the bit and cycle counters are cleared.
REQ-036 Reset mid-frame aborts the frame immediately; txd returns to 1 on that edge and the aborted word is not retransmitted.
REQ-037 After reset deasserts, s_ready = 1 and done = 1 from the first cycle.

Verification
REQ-038 DATA_W=8, baudrate=3, parity 0, stop 0; push 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; then done=1.
REQ-039 parity_sel=1, then 2, 3 and 4, with 0x07 -> parity bit 1, 0, 1 and 0 respectively; stop_sel=1 -> two stop bit periods, 48 cycles total at baudrate=3.
REQ-040 FIFO_DEPTH=4: push 5 words back-to-back while idle -> s_ready=0 after the 4th accepted word; all accepted words are sent in order with a 1-cycle idle gap between frames; fifo_level decrements at each frame start.
REQ-041 Change baudrate from 3 to 7 during DATA -> the current frame completes at 4 cycles per bit; the next frame runs at 8 cycles per bit.
REQ-042 Assert break_req mid-frame for 100 cycles at baudrate=3 -> the frame completes, then txd=0 until break_req falls (min 4 cycles), then IDLE, then queued data resumes.
REQ-043 Assert reset during bit 3 of a frame -> txd=1 and fifo_level=0 on that edge; no further start bit after release without new pushes.
